// File: rtl/vg_pkg.sv
// Shared definitions for the vector-generator sequencer: opcodes, FSM states
// and default memory geometry.
package vg_pkg;

  localparam int AW_DEF = 13;
  localparam int DW_DEF = 16;

  localparam logic [2:0] OP_VCTR = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b001;
  localparam logic [2:0] OP_SVEC = 3'b010;
  localparam logic [2:0] OP_STAT = 3'b011;
  localparam logic [2:0] OP_CNTR = 3'b100;
  localparam logic [2:0] OP_JSR  = 3'b101;
  localparam logic [2:0] OP_RTS  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F0   = 3'd1,
    ST_W0   = 3'd2,
    ST_F1   = 3'd3,
    ST_W1   = 3'd4,
    ST_EXEC = 3'd5
  } vg_state_e;

  // Flow-control ops are executed inside the sequencer and never reach the datapath.
  function automatic logic is_flow_op(input logic [2:0] op);
    return (op == OP_HALT) || (op == OP_JSR) || (op == OP_RTS) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/vg_ret_stack.sv
// Return-address stack for JSR/RTS. Circular: the pointer wraps both ways, so
// overflow overwrites the oldest entry and underflow reads the wrapped one.
module vg_ret_stack
  import vg_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] pop_data
);

  localparam int SPW = $clog2(DEPTH);

  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] top_idx;
  logic [AW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  mem_d [DEPTH];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = '0;
    end else if (push) begin
      mem_d[sp_q] = push_data;
      sp_d        = sp_q + SPW'(1);
    end else if (pop) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

  assign top_idx  = sp_q - SPW'(1);
  assign pop_data = mem_q[top_idx];

endmodule

// File: rtl/vg_seq.sv
// Vector-program sequencer: fetches and decodes vector-memory words, runs flow
// control locally and hands drawing/state commands to the datapath.
//
//   state | meaning
//   IDLE  | halted, waiting for go
//   F0    | read strobe for first instruction word
//   W0    | capture first word, advance pc
//   F1    | read strobe for VCTR second word
//   W1    | capture second word, advance pc
//   EXEC  | execute flow op, or hold command until cmd_ready
module vg_seq
  import vg_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [2:0]    cmd_op,
  output logic [DW-1:0] cmd_w0,
  output logic [DW-1:0] cmd_w1,
  output logic          halted,
  output logic          busy,
  output logic [AW-1:0] pc
);

  vg_state_e     state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir0_q, ir0_d;
  logic [DW-1:0] ir1_q, ir1_d;

  logic [2:0]    op;
  logic [2:0]    rdata_op;
  logic [AW-1:0] target;
  logic [AW-1:0] ret_addr;
  logic          stk_push, stk_pop;

  assign op       = ir0_q[DW-1:DW-3];
  assign rdata_op = mem_rdata[DW-1:DW-3];
  assign target   = ir0_q[AW-1:0];

  vg_ret_stack #(
    .AW    (AW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (go),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q),
    .pop_data  (ret_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir0_q   <= '0;
      ir1_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir0_q   <= ir0_d;
      ir1_q   <= ir1_d;
    end
  end

  // go restarts from any state, including mid-handshake; it wins over cmd_ready.
  always_comb begin
    state_d = state_q;
    if (go) begin
      state_d = ST_F0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_F0:   state_d = ST_W0;
        ST_W0:   state_d = (rdata_op == OP_VCTR) ? ST_F1 : ST_EXEC;
        ST_F1:   state_d = ST_W1;
        ST_W1:   state_d = ST_EXEC;
        ST_EXEC: begin
          if (op == OP_HALT)     state_d = ST_IDLE;
          else if (is_flow_op(op)) state_d = ST_F0;
          else if (cmd_ready)    state_d = ST_F0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d     = pc_q;
    ir0_d    = ir0_q;
    ir1_d    = ir1_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    if (go) begin
      pc_d = '0;
    end else begin
      unique case (state_q)
        ST_W0: begin
          ir0_d = mem_rdata;
          pc_d  = pc_q + AW'(1);
        end
        ST_W1: begin
          ir1_d = mem_rdata;
          pc_d  = pc_q + AW'(1);
        end
        ST_EXEC: begin
          unique case (op)
            OP_JMP: pc_d = target;
            OP_JSR: begin
              stk_push = 1'b1;
              pc_d     = target;
            end
            OP_RTS: begin
              stk_pop = 1'b1;
              pc_d    = ret_addr;
            end
            default: pc_d = pc_q;
          endcase
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    mem_rd    = (state_q == ST_F0) || (state_q == ST_F1);
    mem_addr  = mem_rd ? pc_q : '0;
    cmd_valid = (state_q == ST_EXEC) && !is_flow_op(op);
    cmd_op    = op;
    cmd_w0    = ir0_q;
    cmd_w1    = (op == OP_VCTR) ? ir1_q : '0;
    halted    = (state_q == ST_IDLE);
    busy      = !halted;
    pc        = pc_q;
  end

endmodule

// File: tb/tb_vg_seq.sv
// Directed bench for vg_seq with a one-cycle-latency vector memory model.
module tb_vg_seq;

  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          cmd_valid;
  logic          cmd_ready = 1'b1;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_w0;
  logic [DW-1:0] cmd_w1;
  logic          halted;
  logic          busy;
  logic [AW-1:0] pc;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] vmem [0:(1<<AW)-1];
  logic [AW-1:0] flog [$];

  vg_seq #(.AW(AW), .DW(DW), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_w0    (cmd_w0),
    .cmd_w1    (cmd_w1),
    .halted    (halted),
    .busy      (busy),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= vmem[mem_addr];
      flog.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) vmem[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go    = 1'b0;
    tick(2);
    reset = 1'b0;
    flog.delete();
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  function automatic logic [31:0] flog_at(input int i);
    if (i < flog.size()) return 32'(flog[i]);
    return 32'hFFFF_FFFF;
  endfunction

  logic [AW-1:0] exp_nest [11];

  initial begin
    clear_mem();
    // reset values, observed while reset is still asserted
    reset = 1'b1;
    tick(2);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_op", 32'(cmd_op), 32'd0);
    chk("rst_cmd_w0", 32'(cmd_w0), 32'd0);
    chk("rst_cmd_w1", 32'(cmd_w1), 32'd0);

    // STAT then HALT
    do_reset();
    vmem[0] = 16'h6000;
    vmem[1] = 16'h2000;
    cmd_ready = 1'b1;
    pulse_go();
    chk("t1_f0_rd", 32'(mem_rd), 32'd1);
    chk("t1_f0_addr", 32'(mem_addr), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(1);
    chk("t1_w0_rd", 32'(mem_rd), 32'd0);
    tick(1);
    chk("t1_valid", 32'(cmd_valid), 32'd1);
    chk("t1_op", 32'(cmd_op), 32'd3);
    chk("t1_w0", 32'(cmd_w0), 32'h6000);
    chk("t1_w1", 32'(cmd_w1), 32'd0);
    tick(3);
    chk("t1_not_yet_halted", 32'(halted), 32'd0);
    tick(1);
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_pc", 32'(pc), 32'd2);

    // VCTR with back-pressure
    do_reset();
    clear_mem();
    vmem[0] = 16'h0123;
    vmem[1] = 16'h0456;
    vmem[2] = 16'h2000;
    cmd_ready = 1'b0;
    pulse_go();
    tick(2);
    chk("t2_f1_rd", 32'(mem_rd), 32'd1);
    chk("t2_f1_addr", 32'(mem_addr), 32'd1);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", 32'(cmd_valid), 32'd1);
      chk("t2_hold_w0", 32'(cmd_w0), 32'h0123);
      chk("t2_hold_w1", 32'(cmd_w1), 32'h0456);
      chk("t2_hold_op", 32'(cmd_op), 32'd0);
      tick(1);
    end
    cmd_ready = 1'b1;
    chk("t2_accept_valid", 32'(cmd_valid), 32'd1);
    tick(1);
    chk("t2_next_valid", 32'(cmd_valid), 32'd0);
    chk("t2_next_rd", 32'(mem_rd), 32'd1);
    chk("t2_next_addr", 32'(mem_addr), 32'd2);
    wait_halted("t2_halted", 20);

    // JSR / RTS / HALT
    do_reset();
    clear_mem();
    vmem[0]      = 16'hA100;
    vmem[13'h100] = 16'hC000;
    vmem[1]      = 16'h2000;
    pulse_go();
    wait_halted("t3_halted", 50);
    chk("t3_nfetch", 32'(flog.size()), 32'd3);
    chk("t3_fetch0", flog_at(0), 32'h000);
    chk("t3_fetch1", flog_at(1), 32'h100);
    chk("t3_fetch2", flog_at(2), 32'h001);
    chk("t3_pc", 32'(pc), 32'd2);

    // five nested JSRs overflow the 4-deep stack
    do_reset();
    clear_mem();
    vmem[13'h00] = 16'hA010;
    vmem[13'h10] = 16'hA020;
    vmem[13'h20] = 16'hA030;
    vmem[13'h30] = 16'hA040;
    vmem[13'h40] = 16'hA050;
    vmem[13'h50] = 16'hC000;
    vmem[13'h41] = 16'hC000;
    vmem[13'h31] = 16'hC000;
    vmem[13'h21] = 16'hC000;
    vmem[13'h11] = 16'hC000;
    exp_nest = '{13'h00, 13'h10, 13'h20, 13'h30, 13'h40, 13'h50,
                 13'h41, 13'h31, 13'h21, 13'h11, 13'h41};
    pulse_go();
    begin
      int n;
      n = 0;
      while (flog.size() < 11 && n < 200) begin
        tick(1);
        n++;
      end
    end
    chk("t4_enough_fetches", 32'(flog.size() >= 11), 32'd1);
    for (int i = 0; i < 11; i++) chk("t4_fetch", flog_at(i), 32'(exp_nest[i]));

    // JMP to last address, pc wraps after SVEC
    do_reset();
    clear_mem();
    vmem[0]        = 16'hFFFF;
    vmem[13'h1FFF] = 16'h4ABC;
    cmd_ready = 1'b1;
    pulse_go();
    begin
      int n;
      n = 0;
      while (!cmd_valid && n < 30) begin
        tick(1);
        n++;
      end
    end
    chk("t5_valid", 32'(cmd_valid), 32'd1);
    chk("t5_op", 32'(cmd_op), 32'd2);
    chk("t5_w0", 32'(cmd_w0), 32'h4ABC);
    chk("t5_pc_wrap", 32'(pc), 32'd0);
    chk("t5_fetch1", flog_at(1), 32'h1FFF);
    tick(1);
    chk("t5_wrap_rd", 32'(mem_rd), 32'd1);
    chk("t5_wrap_addr", 32'(mem_addr), 32'd0);

    // go aborts a pending command
    do_reset();
    clear_mem();
    vmem[0] = 16'h6000;
    cmd_ready = 1'b0;
    pulse_go();
    tick(2);
    chk("t6_pending", 32'(cmd_valid), 32'd1);
    pulse_go();
    chk("t6_abort_valid", 32'(cmd_valid), 32'd0);
    chk("t6_abort_rd", 32'(mem_rd), 32'd1);
    chk("t6_abort_addr", 32'(mem_addr), 32'd0);
    chk("t6_abort_pc", 32'(pc), 32'd0);
    tick(1);
    chk("t6_w0_rd", 32'(mem_rd), 32'd0);

    // reset wins over a simultaneous go
    reset = 1'b1;
    go    = 1'b1;
    tick(1);
    reset = 1'b0;
    go    = 1'b0;
    chk("t6_rst_halted", 32'(halted), 32'd1);
    chk("t6_rst_rd", 32'(mem_rd), 32'd0);
    chk("t6_rst_valid", 32'(cmd_valid), 32'd0);
    tick(1);
    chk("t6_rst_still_idle", 32'(halted), 32'd1);
    chk("t6_rst_still_no_rd", 32'(mem_rd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
